pwm_duty_decoder: RTL and testbench
===================================

// Module: pwm_duty_decoder
// PURPOSE
//  Receive side of the sine-PWM link: measures an incoming PWM waveform and recovers each period's
//  duty as an R-bit sample plus the period length in clocks. Sits after the PWM pin (loopback or
//  external), feeding a sample-capture/analysis path. Flags stuck-high/stuck-low lines and overruns.
// PARAMETERS
//  R   6   duty sample width; duty = floor(high*2**R/period), range 0..2**R-1
//  CW  12  high/low/period counter width; saturation value 2**CW-1 marks stuck line
// PORTS
//  clk       in   1   system clock, all logic on posedge
//  rst_n     in   1   asynchronous, active-low reset
//  pwm_in    in   1   asynchronous PWM input
//  en        in   1   measurement enable
//  duty      out  R   last recovered duty sample
//  period    out  CW  last measured period in clocks (rising edge to rising edge)
//  valid     out  1   1-cycle strobe: duty/period updated this cycle
//  stuck_hi  out  1   level: line held high >= 2**CW-1 clocks
//  stuck_lo  out  1   level: line held low  >= 2**CW-1 clocks
//  ovr       out  1   1-cycle strobe: a period completed while divider busy; that period dropped
// BEHAVIOUR
//  Reset: sync FFs=0, FSM=IDLE, counters=0, duty=0, period=0, valid=0, stuck_hi=0, stuck_lo=0, ovr=0.
//  Input: 2-FF synchroniser + edge-detect register; rise/fall seen 3 clocks after pin edge.
//  FSM (IDLE, HIGH, LOW, STUCK):
//   IDLE : counters cleared; rise -> HIGH (hi_cnt=1). Partial first period never reported.
//   HIGH : hi_cnt++ ; fall -> LOW (lo_cnt=1); hi_cnt reaches 2**CW-1 -> STUCK, stuck_hi=1.
//   LOW  : lo_cnt++ ; rise -> period end: launch divide if idle, else ovr pulse; then HIGH, hi_cnt=1,
//          lo_cnt=0; lo_cnt reaches 2**CW-1 -> STUCK, stuck_lo=1.
//   STUCK: hold flag; next opposite edge clears both flags -> HIGH on rise, IDLE on fall.
//  Also stuck_lo asserts from IDLE if no rise within 2**CW-1 clocks (0% duty input).
//  en=0: FSM -> IDLE next clock, in-flight division completes and reports; flags cleared; outputs held.
//  Period end: p=hi_cnt+lo_cnt (CW bits, saturating), h=hi_cnt; both latched into divider.
//  Divider: restoring, 1 quotient bit/clock, R iterations; quotient = floor(h*2**R/p).
//   h<p always, so quotient <= 2**R-1; no saturation needed. p=0 impossible (min 2).
//  Latency: rise detected at cycle t -> duty/period registered and valid=1 at t+R+1.
//  Min reportable period R+1 clocks; shorter periods produce ovr, keep previous duty.
//  Simultaneous period end and divider completion in same cycle: result reported AND new divide
//  launched (divider frees on its last cycle) -> no ovr.
//  Async reset mid-divide: result discarded, no valid.
// STRUCTURE
//  pwm_defs.vh: FSM state localparams, default R/CW, shared with the PWM generator.
//  Sub-module pwm_div_seq: start/h/p in, busy, done, quotient out; R-cycle restoring divider.
//  Top: synchroniser, edge detect, FSM, counters, output registers.
// TESTING (R=6, CW=12)
//  1. Reset mid-period with pwm_in toggling -> all outputs 0, no valid until 2 full rises after release.
//  2. Period 64, high 32 -> duty=32, period=64, valid exactly 7 clocks after synced rise.
//  3. Period 64, high 63 -> duty=63; period 128, high 1 -> duty=0 (floor), period=128.
//  4. Hold pwm_in low 4095 clocks -> stuck_lo=1; rise -> stuck_lo=0, next full period reports normally.
//  5. Period 4 (high 2) -> ovr pulses on periods while busy, duty keeps prior value.
//  6. Drive generator sine sequence (36 steps) -> recovered duty tracks table within +/-1 LSB.

Source files
------------

// File: rtl/pwm_duty_decoder_pkg.sv
// Shared definitions for the PWM duty decoder: FSM state encoding and default widths.
package pwm_duty_decoder_pkg;

    // Default duty sample width and counter width.
    localparam int R_DEFAULT  = 6;
    localparam int CW_DEFAULT = 12;

    // Measurement FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HIGH  = 2'd1,
        ST_LOW   = 2'd2,
        ST_STUCK = 2'd3
    } state_t;

endpackage

// File: rtl/pwm_duty_decoder_div.sv
// Sequential restoring divider: quotient = floor(h * 2**R / p) for h < p,
// one quotient bit per clock. A start is accepted while idle or on the
// finishing cycle, so back-to-back divides lose no clock.
module pwm_duty_decoder_div #(
    parameter int R  = 6,
    parameter int CW = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [CW-1:0] h,
    input  logic [CW-1:0] p,
    output logic          busy,
    output logic          done,
    output logic [R-1:0]  quotient,
    output logic [CW-1:0] divisor
);

    localparam int CNTW = $clog2(R + 1);

    logic [CNTW-1:0] cnt;
    logic [CW-1:0]   rem;
    logic [CW:0]     rem_sh;
    logic [R-1:0]    quo;
    logic [CW-1:0]   div_q;

    // Remainder is always below the divisor, so shifting it left needs one extra bit.
    assign rem_sh   = {rem, 1'b0};
    assign done     = busy && (cnt == CNTW'(R));
    assign quotient = quo;
    assign divisor  = div_q;

    // Load operands on start, then produce one quotient bit per clock until R bits are done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy  <= 1'b0;
            cnt   <= '0;
            rem   <= '0;
            quo   <= '0;
            div_q <= '0;
        end else if (start) begin
            busy  <= 1'b1;
            cnt   <= '0;
            rem   <= h;
            quo   <= '0;
            div_q <= p;
        end else if (done) begin
            busy <= 1'b0;
        end else if (busy) begin
            cnt <= cnt + 1'b1;
            if (rem_sh >= {1'b0, div_q}) begin
                rem <= CW'(rem_sh - {1'b0, div_q});
                quo <= {quo[R-2:0], 1'b1};
            end else begin
                rem <= rem_sh[CW-1:0];
                quo <= {quo[R-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/pwm_duty_decoder.sv
// Receive side of the PWM link: synchronises the pin, measures high and low
// times per period, divides high by period into an R-bit duty sample and
// flags stuck lines and periods dropped while the divider is busy.
module pwm_duty_decoder
    import pwm_duty_decoder_pkg::*;
#(
    parameter int R  = R_DEFAULT,
    parameter int CW = CW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pwm_in,
    input  logic          en,
    output logic [R-1:0]  duty,
    output logic [CW-1:0] period,
    output logic          valid,
    output logic          stuck_hi,
    output logic          stuck_lo,
    output logic          ovr
);

    localparam logic [CW-1:0] SAT    = {CW{1'b1}};
    localparam logic [CW-1:0] SAT_M1 = SAT - 1'b1;

    logic s_meta, s_sync, s_prev;
    logic rise, fall;

    state_t        state, state_next;
    logic [CW-1:0] hi_cnt, hi_next;
    logic [CW-1:0] lo_cnt, lo_next;
    logic          stuck_hi_next, stuck_lo_next;
    logic          launch, ovr_next;

    logic [CW:0]   sum;
    logic [CW-1:0] p_sat;

    logic          div_busy, div_done;
    logic [R-1:0]  div_quo;
    logic [CW-1:0] div_p;
    logic          div_ready;

    // Two-flop synchroniser followed by an edge-detect register.
    // NOTE: every clocked block uses non-blocking assignments so the three flops
    // shift one stage per clock instead of collapsing into a single wire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_meta <= 1'b0;
            s_sync <= 1'b0;
            s_prev <= 1'b0;
        end else begin
            s_meta <= pwm_in;
            s_sync <= s_meta;
            s_prev <= s_sync;
        end
    end

    assign rise = s_sync & ~s_prev;
    assign fall = ~s_sync & s_prev;

    // Period length saturates at the counter limit; h < p still holds because lo_cnt >= 1.
    assign sum       = {1'b0, hi_cnt} + {1'b0, lo_cnt};
    assign p_sat     = sum[CW] ? SAT : sum[CW-1:0];
    assign div_ready = !div_busy || div_done;

    // FSM state, counters and stuck flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            hi_cnt   <= '0;
            lo_cnt   <= '0;
            stuck_hi <= 1'b0;
            stuck_lo <= 1'b0;
        end else begin
            state    <= state_next;
            hi_cnt   <= hi_next;
            lo_cnt   <= lo_next;
            stuck_hi <= stuck_hi_next;
            stuck_lo <= stuck_lo_next;
        end
    end

    // Next-state, counter and period-end decisions.
    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_next    = state;
        hi_next       = hi_cnt;
        lo_next       = lo_cnt;
        stuck_hi_next = stuck_hi;
        stuck_lo_next = stuck_lo;
        launch        = 1'b0;
        ovr_next      = 1'b0;

        if (!en) begin
            state_next    = ST_IDLE;
            hi_next       = '0;
            lo_next       = '0;
            stuck_hi_next = 1'b0;
            stuck_lo_next = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // lo_cnt doubles as the no-rise timer for a 0% duty line.
                    hi_next = '0;
                    if (rise) begin
                        state_next = ST_HIGH;
                        hi_next    = 1;
                        lo_next    = '0;
                    end else if (s_sync) begin
                        lo_next = '0;
                    end else if (lo_cnt == SAT_M1) begin
                        state_next    = ST_STUCK;
                        stuck_lo_next = 1'b1;
                        lo_next       = '0;
                    end else begin
                        lo_next = lo_cnt + 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (fall) begin
                        state_next = ST_LOW;
                        lo_next    = 1;
                    end else if (hi_cnt == SAT_M1) begin
                        state_next    = ST_STUCK;
                        stuck_hi_next = 1'b1;
                        hi_next       = '0;
                        lo_next       = '0;
                    end else begin
                        hi_next = hi_cnt + 1'b1;
                    end
                end
                ST_LOW: begin
                    if (rise) begin
                        launch     = div_ready;
                        ovr_next   = !div_ready;
                        state_next = ST_HIGH;
                        hi_next    = 1;
                        lo_next    = '0;
                    end else if (lo_cnt == SAT_M1) begin
                        state_next    = ST_STUCK;
                        stuck_lo_next = 1'b1;
                        hi_next       = '0;
                        lo_next       = '0;
                    end else begin
                        lo_next = lo_cnt + 1'b1;
                    end
                end
                ST_STUCK: begin
                    if (stuck_hi && fall) begin
                        state_next    = ST_IDLE;
                        stuck_hi_next = 1'b0;
                        stuck_lo_next = 1'b0;
                    end else if (stuck_lo && rise) begin
                        state_next    = ST_HIGH;
                        hi_next       = 1;
                        lo_next       = '0;
                        stuck_hi_next = 1'b0;
                        stuck_lo_next = 1'b0;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    hi_next    = '0;
                    lo_next    = '0;
                end
            endcase
        end
    end

    pwm_duty_decoder_div #(
        .R  (R),
        .CW (CW)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (launch),
        .h        (hi_cnt),
        .p        (p_sat),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quo),
        .divisor  (div_p)
    );

    // Result registers: capture the divider output on completion, strobe valid and overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty   <= '0;
            period <= '0;
            valid  <= 1'b0;
            ovr    <= 1'b0;
        end else begin
            valid <= div_done;
            ovr   <= ovr_next;
            if (div_done) begin
                duty   <= div_quo;
                period <= div_p;
            end
        end
    end

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Self-checking bench for pwm_duty_decoder (R=6, CW=12): table of period
// vectors plus directed sequences for latency, stuck lines, overrun and reset.
`timescale 1ns/1ps
module tb_pwm_duty_decoder;

    localparam int R  = 6;
    localparam int CW = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          pwm_in;
    logic          en;
    logic [R-1:0]  duty;
    logic [CW-1:0] period;
    logic          valid;
    logic          stuck_hi;
    logic          stuck_lo;
    logic          ovr;

    pwm_duty_decoder #(.R(R), .CW(CW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pwm_in   (pwm_in),
        .en       (en),
        .duty     (duty),
        .period   (period),
        .valid    (valid),
        .stuck_hi (stuck_hi),
        .stuck_lo (stuck_lo),
        .ovr      (ovr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int high;
        int per;
        int exp_duty;
        int exp_period;
    } vec_t;

    typedef struct {
        int duty;
        int period;
    } rpt_t;

    int   n_checks = 0;
    int   n_errors = 0;
    rpt_t exp_q[$];
    rpt_t mon_e;
    rpt_t fix_e;
    bit   fixed_mode = 1'b0;
    int   valid_cnt = 0;
    int   ovr_cnt = 0;
    int   first_ovr_duty = -1;
    vec_t vecs[12];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Every valid strobe is compared against the next expected report.
    always @(negedge clk) begin
        if (valid) begin
            valid_cnt++;
            if (fixed_mode) begin
                check("fixed_duty", int'(duty), fix_e.duty);
                check("fixed_period", int'(period), fix_e.period);
            end else if (exp_q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("duty", int'(duty), mon_e.duty);
                check("period", int'(period), mon_e.period);
            end
        end
        if (ovr) begin
            ovr_cnt++;
            if (ovr_cnt == 1) first_ovr_duty = int'(duty);
        end
    end

    // One PWM period aligned to the falling clock edge; optionally queue its expected report.
    task automatic drive_period(input int h, input int p, input bit push, input int ed, input int ep);
        rpt_t r;
        pwm_in = 1'b1;
        repeat (h) @(negedge clk);
        pwm_in = 1'b0;
        repeat (p - h) @(negedge clk);
        if (push) begin
            r.duty   = ed;
            r.period = ep;
            exp_q.push_back(r);
        end
    endtask

    // Final rise closes the last period, then en pulses low to return the FSM to IDLE.
    task automatic end_seq();
        pwm_in = 1'b1;
        repeat (20) @(negedge clk);
        en     = 1'b0;
        pwm_in = 1'b0;
        repeat (5) @(negedge clk);
        en = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_duty"}, int'(duty), 0);
        check({tag, "_period"}, int'(period), 0);
        check({tag, "_valid"}, int'(valid), 0);
        check({tag, "_stuck_hi"}, int'(stuck_hi), 0);
        check({tag, "_stuck_lo"}, int'(stuck_lo), 0);
        check({tag, "_ovr"}, int'(ovr), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int h;

        vecs[0]  = '{32,   64,   32, 64};
        vecs[1]  = '{63,   64,   63, 64};
        vecs[2]  = '{1,    128,  0,  128};
        vecs[3]  = '{16,   64,   16, 64};
        vecs[4]  = '{10,   30,   21, 30};
        vecs[5]  = '{3,    7,    27, 7};
        vecs[6]  = '{3,    7,    27, 7};
        vecs[7]  = '{4,    7,    36, 7};
        vecs[8]  = '{2000, 4000, 32, 4000};
        vecs[9]  = '{100,  4000, 1,  4000};
        vecs[10] = '{1,    4095, 0,  4095};
        vecs[11] = '{3000, 6000, 46, 4095};

        // Reset with the input toggling: everything stays at zero.
        rst_n  = 1'b0;
        en     = 1'b0;
        pwm_in = 1'b0;
        repeat (6) begin
            @(negedge clk);
            pwm_in = ~pwm_in;
        end
        check_all_zero("reset");
        pwm_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;
        repeat (5) @(negedge clk);

        // Table of periods, including min reportable period and saturating length.
        for (int i = 0; i < 12; i++)
            drive_period(vecs[i].high, vecs[i].per, 1'b1, vecs[i].exp_duty, vecs[i].exp_period);
        end_seq();
        check("table_reports_pending", exp_q.size(), 0);

        // Latency: pin rise to valid is 3 sync clocks plus R+1.
        drive_period(32, 64, 1'b1, 32, 64);
        pwm_in = 1'b1;
        n = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            n++;
            if (valid) break;
        end
        check("latency_clocks", n, 3 + R + 1);
        @(negedge clk);
        end_seq();

        // Line held low: stuck_lo after 2**CW-1 clocks, cleared by a rise.
        repeat (4000) @(negedge clk);
        check("stuck_lo_early", int'(stuck_lo), 0);
        repeat (110) @(negedge clk);
        check("stuck_lo_set", int'(stuck_lo), 1);
        check("stuck_hi_quiet", int'(stuck_hi), 0);
        pwm_in = 1'b1;
        repeat (5) @(negedge clk);
        check("stuck_lo_clear", int'(stuck_lo), 0);
        repeat (11) @(negedge clk);
        pwm_in = 1'b0;
        repeat (48) @(negedge clk);
        exp_q.push_back('{16, 64});

        // Line held high: stuck_hi, cleared by a fall.
        pwm_in = 1'b1;
        repeat (4110) @(negedge clk);
        check("stuck_hi_set", int'(stuck_hi), 1);
        pwm_in = 1'b0;
        repeat (5) @(negedge clk);
        check("stuck_hi_clear", int'(stuck_hi), 0);
        check("stuck_lo_after_hi", int'(stuck_lo), 0);
        check("stuck_reports_pending", exp_q.size(), 0);

        // Period 4: every other period overruns, duty holds until the next report.
        valid_cnt  = 0;
        ovr_cnt    = 0;
        fix_e      = '{32, 4};
        fixed_mode = 1'b1;
        repeat (12) drive_period(2, 4, 1'b0, 0, 0);
        pwm_in = 1'b1;
        repeat (20) @(negedge clk);
        fixed_mode = 1'b0;
        check("short_valid_count", valid_cnt, 6);
        check("short_ovr_count", ovr_cnt, 6);
        check("duty_held_at_ovr", first_ovr_duty, 16);
        end_seq();

        // Sine sequence at period 64: recovered duty equals the high time.
        for (int k = 0; k < 36; k++) begin
            h = 32 + $rtoi(28.0 * $sin(6.283185307 * k / 36.0));
            drive_period(h, 64, 1'b1, h, 64);
        end
        end_seq();
        check("sine_reports_pending", exp_q.size(), 0);

        // Reset during a divide: result dropped, first report after two rises.
        drive_period(40, 64, 1'b0, 0, 0);
        pwm_in = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        repeat (4) begin
            @(negedge clk);
            pwm_in = ~pwm_in;
        end
        pwm_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check_all_zero("after_reset");
        drive_period(20, 64, 1'b1, 20, 64);
        end_seq();
        check("reset_reports_pending", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
